// File: rtl/mvm_host_ctrl.sv
// Host-side sequencer for the mvm core: stages commands and data, replays them to the
// core as gap-free load/start sequences, and streams the captured result burst out.
module mvm_host_ctrl #(
    parameter int M  = 12,
    parameter int T  = 20,
    parameter int OW = 2 * T
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [T-1:0]  s_data,
    output logic                 loadMatrix,
    output logic                 loadVector,
    output logic                 start,
    output logic signed [T-1:0]  data_in,
    input  logic                 done,
    input  logic signed [OW-1:0] data_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [OW-1:0] m_data,
    output logic                 m_last
);

    localparam int N  = M * M;
    localparam int CW = $clog2(M * M + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {
        IDLE, FILL, PULSE, BURST, START, WAIT_DONE, CAPTURE, DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         len_q, len_d;
    logic                  mat_q, mat_d;
    logic                  stage_we, res_we;

    logic signed [T-1:0]   stage_mem [N];
    logic signed [OW-1:0]  res_mem   [M];

    logic                  cmd_ready_q, s_ready_q, ldm_q, ldv_q, start_q;
    logic                  m_valid_q, m_last_q, m_last_d;
    logic signed [T-1:0]   data_in_q, data_in_d;
    logic signed [OW-1:0]  m_data_q, m_data_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mat_d     = mat_q;
        data_in_d = '0;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        stage_we  = 1'b0;
        res_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd)
                        2'd0: begin
                            mat_d   = 1'b1;
                            len_d   = CW'(N);
                            cnt_d   = '0;
                            state_d = FILL;
                        end
                        2'd1: begin
                            mat_d   = 1'b0;
                            len_d   = CW'(M);
                            cnt_d   = '0;
                            state_d = FILL;
                        end
                        2'd2:    state_d = START;
                        default: state_d = IDLE;
                    endcase
                end
            end
            FILL: begin
                if (s_valid && s_ready_q) begin
                    stage_we = 1'b1;
                    if (cnt_q == len_q - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = PULSE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PULSE: begin
                // Pre-fetch word 0 so the burst follows the pulse with no gap.
                data_in_d = stage_mem[0];
                cnt_d     = CW'(1);
                state_d   = BURST;
            end
            BURST: begin
                if (cnt_q == len_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    data_in_d = stage_mem[cnt_q[AW-1:0]];
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (done) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                res_we = 1'b1;
                if (cnt_q == CW'(M - 1)) begin
                    // With a single-word result, word 0 is being written this edge.
                    m_data_d = (cnt_q == '0) ? data_out : res_mem[0];
                    m_last_d = (M == 1);
                    cnt_d    = '0;
                    state_d  = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready) begin
                    if (cnt_q == CW'(M - 1)) begin
                        m_data_d = '0;
                        m_last_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        m_data_d = res_mem[cnt_q[RW-1:0] + RW'(1)];
                        m_last_d = (cnt_q == CW'(M - 2));
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so every strobe lines up with its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mat_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            ldm_q       <= 1'b0;
            ldv_q       <= 1'b0;
            start_q     <= 1'b0;
            data_in_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            mat_q       <= mat_d;
            cmd_ready_q <= (state_d == IDLE);
            s_ready_q   <= (state_d == FILL);
            ldm_q       <= (state_d == PULSE) && mat_d;
            ldv_q       <= (state_d == PULSE) && !mat_d;
            start_q     <= (state_d == START);
            data_in_q   <= data_in_d;
            m_valid_q   <= (state_d == DRAIN);
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (stage_we) stage_mem[cnt_q[AW-1:0]] <= s_data;
        if (res_we)   res_mem[cnt_q[RW-1:0]]   <= data_out;
    end

    assign cmd_ready  = cmd_ready_q;
    assign s_ready    = s_ready_q;
    assign loadMatrix = ldm_q;
    assign loadVector = ldv_q;
    assign start      = start_q;
    assign data_in    = data_in_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;

endmodule

// File: tb/tb_mvm_host_ctrl.sv
// Directed bench for mvm_host_ctrl with a small behavioral core that answers start
// with done followed by the result words 1000+j.
module tb_mvm_host_ctrl;
    localparam int M  = 12;
    localparam int T  = 20;
    localparam int OW = 2 * T;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic s_valid = 1'b0;
    logic signed [T-1:0] s_data = '0;
    logic done = 1'b0;
    logic signed [OW-1:0] data_out = '0;
    logic m_ready = 1'b0;

    logic cmd_ready, s_ready, loadMatrix, loadVector, start, m_valid, m_last;
    logic signed [T-1:0]  data_in;
    logic signed [OW-1:0] m_data;

    int total = 0;
    int bad = 0;
    int start_seen = 0;
    int ldm_seen = 0;
    int ldv_seen = 0;

    mvm_host_ctrl #(.M(M), .T(T), .OW(OW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
        .data_in(data_in), .done(done), .data_out(data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start)      start_seen <= start_seen + 1;
        if (loadMatrix) ldm_seen   <= ldm_seen + 1;
        if (loadVector) ldv_seen   <= ldv_seen + 1;
    end

    // Behavioral core: done a few cycles after start, then M result words.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start) begin
                repeat (6) @(posedge clk);
                #1 done = 1'b1;
                @(posedge clk);
                #1 done = 1'b0;
                for (int j = 0; j < M; j++) begin
                    data_out = OW'(1000 + j);
                    @(posedge clk);
                    #1;
                end
                data_out = '0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd = c;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_accept_wait", 64'(n < 50), 1);
        tick();
        cmd_valid = 1'b0;
        cmd = 2'd0;
    endtask

    task automatic fill(input int n, input int first, input bit gaps);
        int stray;
        int w;
        stray = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!s_ready && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) begin
                chk("s_ready_wait", 0, 1);
                s_valid = 1'b0;
                return;
            end
            s_valid = 1'b1;
            s_data = T'(first + i);
            stray += int'(loadMatrix) + int'(loadVector);
            tick();
            s_valid = 1'b0;
            if (gaps && i < n - 1) begin
                stray += int'(loadMatrix) + int'(loadVector);
                tick();
            end
        end
        chk("no_early_pulse", stray, 0);
    endtask

    // Called in the cycle right after the last fill handshake.
    task automatic check_burst(input int n, input int first, input bit is_mat);
        int extra;
        extra = 0;
        chk("pulse_matrix", loadMatrix, is_mat);
        chk("pulse_vector", loadVector, !is_mat);
        chk("fill_closed", s_ready, 0);
        tick();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("burst[%0d]", k), data_in, first + k);
            extra += int'(loadMatrix) + int'(loadVector) + int'(cmd_ready);
            tick();
        end
        chk("burst_quiet", extra, 0);
        chk("burst_end_data", data_in, 0);
        chk("burst_end_ready", cmd_ready, 1);
    endtask

    initial begin
        int s0, n, j, cyc, l0, v0;

        // Reset held for two edges
        repeat (2) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_strobes", {s_ready, loadMatrix, loadVector, start, m_valid, m_last}, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_m_data", m_data, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_s_ready", s_ready, 0);

        // Reserved command
        s0 = start_seen; l0 = ldm_seen; v0 = ldv_seen;
        cmd_valid = 1'b1;
        cmd = 2'd3;
        tick();
        cmd_valid = 1'b0;
        cmd = 2'd0;
        chk("rsv_ready", cmd_ready, 1);
        chk("rsv_s_ready", s_ready, 0);
        repeat (3) tick();
        chk("rsv_s_ready_later", s_ready, 0);
        chk("rsv_no_pulses", (start_seen - s0) + (ldm_seen - l0) + (ldv_seen - v0), 0);

        // Matrix load with input stalls
        l0 = ldm_seen;
        send_cmd(2'd0);
        chk("mat_cmd_busy", cmd_ready, 0);
        fill(M * M, 1, 1'b1);
        check_burst(M * M, 1, 1'b1);
        chk("mat_one_pulse", ldm_seen - l0, 1);

        // Vector load then compute
        send_cmd(2'd1);
        fill(M, -5, 1'b1);
        check_burst(M, -5, 1'b0);
        send_cmd(2'd2);
        chk("start_pulse", start, 1);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        chk("result_latency", n, 19);
        m_ready = 1'b1;
        for (int k = 0; k < M; k++) begin
            chk("res_valid", m_valid, 1);
            chk($sformatf("res[%0d]", k), m_data, 1000 + k);
            chk($sformatf("res_last[%0d]", k), m_last, 64'(k == M - 1));
            tick();
        end
        m_ready = 1'b0;
        chk("res_end_valid", m_valid, 0);
        chk("res_end_ready", cmd_ready, 1);

        // Backpressure on the result stream
        s0 = start_seen;
        send_cmd(2'd2);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 19);
        repeat (3) begin
            chk("bp_hold_data", m_data, 1000);
            chk("bp_hold_valid", m_valid, 1);
            tick();
        end
        j = 0;
        cyc = 0;
        while (j < M && cyc < 100) begin
            m_ready = (cyc % 2 == 0);
            chk("bp_valid", m_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            if (m_ready) begin
                chk($sformatf("bp_res[%0d]", j), m_data, 1000 + j);
                chk($sformatf("bp_last[%0d]", j), m_last, 64'(j == M - 1));
                j++;
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        chk("bp_count", j, M);
        chk("bp_end_ready", cmd_ready, 1);
        chk("bp_end_valid", m_valid, 0);
        chk("bp_one_start", start_seen - s0, 1);

        // Reset while word 50 of a matrix burst is on data_in
        send_cmd(2'd0);
        fill(M * M, 1, 1'b0);
        tick();
        repeat (50) tick();
        chk("pre_abort_word", data_in, 51);
        reset = 1'b1;
        tick();
        chk("abort_data_in", data_in, 0);
        chk("abort_load", loadMatrix, 0);
        chk("abort_ready", cmd_ready, 0);
        reset = 1'b0;
        tick();
        chk("abort_release_ready", cmd_ready, 1);
        send_cmd(2'd0);
        fill(M * M, -100, 1'b0);
        check_burst(M * M, -100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
